// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_pkg : shared types and helpers for the 8N1 serial receiver    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package uart_pkg;

  localparam int OVERSAMPLE_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_e;

  // Clocks per oversample tick, rounded to nearest and never below 1.
  function automatic int calc_div(input int clk_freq, input int baud, input int os);
    longint den;
    longint q;
    den = longint'(baud) * longint'(os);
    q   = (longint'(clk_freq) + den / 2) / den;
    return (q < 1) ? 1 : int'(q);
  endfunction

endpackage
`default_nettype wire

// File: rtl/baud_tick_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | baud_tick_gen : free-running divider, one-cycle tick every DIV clk |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module baud_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             wrap;

  always_comb begin
    wrap  = (cnt_q == CNT_MAX);
    cnt_d = cnt_q + CNT_W'(1);
    if (clr || wrap) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A clear takes priority so the first tick after a start lands exactly DIV clk later.
  assign tick = wrap && !clr;

endmodule
`default_nettype wire

// File: rtl/uart_rx_mode.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_rx_mode : oversampling 8N1 receiver holding the last good byte|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module uart_rx_mode
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy,
  output logic [7:0] mode_byte
);

  localparam int DIV   = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int SUB_W = $clog2(OVERSAMPLE);
  localparam logic [SUB_W-1:0] SUB_HALF = SUB_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVERSAMPLE - 1);

  rx_state_e        state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic [SUB_W-1:0] sub_q, sub_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_out_q, data_out_d;
  logic [7:0]       mode_byte_q, mode_byte_d;
  logic             data_valid_q, data_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             tick_clr;
  logic             tick;
  logic             rxs;

  baud_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .tick (tick)
  );

  assign sync_d = {sync_q[0], rxd};
  assign rxs    = sync_q[1];

  always_comb begin
    state_d      = state_q;
    sub_d        = sub_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    data_out_d   = data_out_q;
    mode_byte_d  = mode_byte_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    tick_clr     = 1'b0;

    unique case (state_q)
      IDLE: begin
        tick_clr = 1'b1;
        sub_d    = '0;
        bit_d    = '0;
        if (!rxs) begin
          state_d = START;
        end
      end

      START: begin
        if (tick) begin
          if (sub_q == SUB_HALF) begin
            sub_d   = '0;
            bit_d   = '0;
            state_d = rxs ? IDLE : DATA;
          end else begin
            sub_d = sub_q + SUB_W'(1);
          end
        end
      end

      DATA: begin
        if (tick) begin
          if (sub_q == SUB_LAST) begin
            sub_d   = '0;
            shift_d = {rxs, shift_q[7:1]};
            if (bit_q == 3'd7) begin
              state_d = STOP;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end else begin
            sub_d = sub_q + SUB_W'(1);
          end
        end
      end

      STOP: begin
        if (tick) begin
          if (sub_q == SUB_LAST) begin
            sub_d = '0;
            if (rxs) begin
              data_out_d   = shift_q;
              mode_byte_d  = shift_q;
              data_valid_d = 1'b1;
              state_d      = IDLE;
            end else begin
              // A low stop bit may be a break; hold off until the line recovers.
              frame_err_d = 1'b1;
              state_d     = WAIT_HIGH;
            end
          end else begin
            sub_d = sub_q + SUB_W'(1);
          end
        end
      end

      WAIT_HIGH: begin
        if (rxs) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sync_q       <= 2'b11;
      sub_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      data_out_q   <= '0;
      mode_byte_q  <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      sub_q        <= sub_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      data_out_q   <= data_out_d;
      mode_byte_q  <= mode_byte_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign data_out   = data_out_q;
  assign mode_byte  = mode_byte_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_mode.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------+
// | tb_uart_rx_mode : directed and randomised frames vs. a byte model  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_uart_rx_mode;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 25_000;
  localparam int OS       = 16;
  localparam int BIT_CLK  = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] data_out;
  logic [7:0] mode_byte;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  int n_cmp  = 0;
  int n_bad  = 0;
  int dv_cnt = 0;
  int fe_cnt = 0;
  int cyc    = 0;
  logic prev_dv = 1'b0;
  logic prev_fe = 1'b0;
  logic [7:0] rx_q[$];
  int         dv_cyc[$];
  logic [7:0] exp_mode = 8'h00;

  uart_rx_mode #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy),
    .mode_byte  (mode_byte)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Strobe monitor: collects received bytes and strobe timestamps.
  always @(negedge clk) begin
    if (data_valid) begin
      dv_cnt++;
      rx_q.push_back(data_out);
      dv_cyc.push_back(cyc);
      check("dv_one_cycle", {31'd0, prev_dv}, 32'd0);
    end
    if (frame_err) begin
      fe_cnt++;
      check("fe_one_cycle", {31'd0, prev_fe}, 32'd0);
    end
    if (data_valid || frame_err)
      check("strobe_exclusive", {31'd0, data_valid && frame_err}, 32'd0);
    prev_dv = data_valid;
    prev_fe = frame_err;
  end

  task automatic send_frame(input logic [7:0] b, input logic stop, input int bitclk);
    rxd = 1'b0;
    repeat (bitclk) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (bitclk) @(negedge clk);
    end
    rxd = stop;
    repeat (bitclk) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_data_out"}, {24'd0, data_out}, {24'd0, exp_mode});
    check({tag, "_mode_byte"}, {24'd0, mode_byte}, {24'd0, exp_mode});
  endtask

  task automatic good_frame(input string tag, input logic [7:0] b, input int bitclk);
    int dv0, fe0;
    logic [7:0] got;
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    rx_q.delete();
    send_frame(b, 1'b1, bitclk);
    wait_idle(tag);
    exp_mode = b;
    check({tag, "_dv_pulses"}, dv_cnt - dv0, 32'd1);
    check({tag, "_fe_pulses"}, fe_cnt - fe0, 32'd0);
    got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
    check({tag, "_strobe_byte"}, {24'd0, got}, {24'd0, b});
    check_outputs(tag);
  endtask

  task automatic bad_frame(input string tag, input logic [7:0] b, input int bitclk, input int extra_low);
    int dv0, fe0;
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    send_frame(b, 1'b0, bitclk);
    repeat (extra_low) @(negedge clk);
    check({tag, "_busy_while_low"}, {31'd0, busy}, 32'd1);
    rxd = 1'b1;
    wait_idle(tag);
    check({tag, "_fe_pulses"}, fe_cnt - fe0, 32'd1);
    check({tag, "_dv_pulses"}, dv_cnt - dv0, 32'd0);
    check_outputs(tag);
  endtask

  initial begin
    #200_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dv0, fe0, n;
    logic [7:0] b, b2, got;
    int bitclk;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_data_out", {24'd0, data_out}, 32'd0);
    check("rst_mode_byte", {24'd0, mode_byte}, 32'd0);
    check("rst_data_valid", {31'd0, data_valid}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    good_frame("good_41", 8'h41, BIT_CLK);

    // Glitch: short low pulse must be rejected at mid start bit
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    rxd = 1'b0;
    repeat (12) @(negedge clk);
    rxd = 1'b1;
    n = 12;
    while (busy !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("glitch_busy_40", {31'd0, busy}, 32'd0);
    repeat (20) @(negedge clk);
    check("glitch_dv", dv_cnt - dv0, 32'd0);
    check("glitch_fe", fe_cnt - fe0, 32'd0);
    check_outputs("glitch");

    // Framing error with long break, then recovery
    bad_frame("ferr_3c", 8'h3C, BIT_CLK, 200 - BIT_CLK);
    good_frame("after_ferr_12", 8'h12, BIT_CLK);

    // Back-to-back frames
    dv0 = dv_cnt;
    rx_q.delete();
    dv_cyc.delete();
    send_frame(8'h55, 1'b1, BIT_CLK);
    send_frame(8'hAA, 1'b1, BIT_CLK);
    wait_idle("b2b");
    check("b2b_dv_pulses", dv_cnt - dv0, 32'd2);
    got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
    check("b2b_first", {24'd0, got}, 32'h55);
    got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
    check("b2b_second", {24'd0, got}, 32'hAA);
    check("b2b_spacing", (dv_cyc.size() == 2) ? dv_cyc[1] - dv_cyc[0] : -1, 32'd640);
    exp_mode = 8'hAA;
    check_outputs("b2b");

    // Skewed baud
    good_frame("skew_fast_a5", 8'hA5, 62);
    good_frame("skew_slow_a5", 8'hA5, 66);

    // Randomised frames against the byte model
    for (int k = 0; k < 8; k++) begin
      b      = 8'($urandom);
      bitclk = $urandom_range(62, 66);
      if ($urandom_range(0, 3) == 0)
        bad_frame("rand_ferr", b, bitclk, $urandom_range(0, 100));
      else
        good_frame("rand_good", b, bitclk);
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end

    // Back-to-back random pair
    b  = 8'($urandom);
    b2 = 8'($urandom);
    dv0 = dv_cnt;
    rx_q.delete();
    send_frame(b, 1'b1, BIT_CLK);
    send_frame(b2, 1'b1, BIT_CLK);
    wait_idle("rb2b");
    check("rb2b_dv_pulses", dv_cnt - dv0, 32'd2);
    got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
    check("rb2b_first", {24'd0, got}, {24'd0, b});
    got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
    check("rb2b_second", {24'd0, got}, {24'd0, b2});
    exp_mode = b2;
    good_frame("pre_reset_c3", 8'hC3, BIT_CLK);

    // Reset during bit 4 of 0xF0
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    b   = 8'hF0;
    rxd = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd = b[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    rxd = b[4];
    repeat (BIT_CLK / 2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    exp_mode = 8'h00;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_dv", {31'd0, data_valid}, 32'd0);
    check("midrst_fe", {31'd0, frame_err}, 32'd0);
    check_outputs("midrst");
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (700) @(negedge clk);
    check("midrst_no_dv", dv_cnt - dv0, 32'd0);
    check("midrst_no_fe", fe_cnt - fe0, 32'd0);
    check("midrst_busy_after", {31'd0, busy}, 32'd0);
    good_frame("after_rst_0f", 8'h0F, BIT_CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
